board_line_clear: RTL and testbench
===================================

Name: board_line_clear

Overview:
- Owns the 10x20 playfield occupancy store, directly downstream of the game-logic FSM.
- Absorbs that FSM's single-cell lock writes and serves its combinational collision read port.
- Serves a row-wide read port for the VGA renderer.
- After each lock, on request, scans the board bottom-up, removes every full row by shifting rows above it down, and reports the number of rows removed.

Parameters:
COLS, 10, board width in cells (x = 0..COLS-1)
ROWS, 20, board height in cells (y = 0..ROWS-1, y=0 top)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
board_we  in  1  write enable from game logic, one cell per cycle
board_wx  in  4  write column
board_wy  in  5  write row
board_wdata  in  1  value to store (1 = occupied)
board_rx  in  4  collision read column
board_ry  in  5  collision read row
board_rdata  out  1  occupancy of (board_rx, board_ry), combinational
vga_ry  in  5  renderer row select
vga_row  out  COLS  occupancy bits of row vga_ry, combinational; bit i = column i
clear_start  in  1  one-cycle pulse: begin line-clear pass
busy  out  1  pass in progress
done  out  1  one-cycle pulse: pass finished
lines_cleared  out  3  rows removed in last pass, saturating at 7
lines_total  out  8  cumulative rows removed since reset, saturating at 255

Behaviour:
- Storage: ROWS registers of COLS bits; reset clears all to 0.
- Output reset values: busy=0, done=0, lines_cleared=0, lines_total=0.
- Write: when board_we=1 and state=S_IDLE, cell (wx,wy) takes wdata at the next edge.
- Ignored writes: any write with wx>=COLS or wy>=ROWS; any write while state!=S_IDLE.
- Collision read: board_rdata is combinational, zero latency. Returns 1 when rx>=COLS or ry>=ROWS (out of range reads as wall).
- VGA read: vga_row is combinational. Returns all-0 when vga_ry>=ROWS.
- During a pass, both read ports return live register contents, including mid-shift.
- S_IDLE:
  - clear_start=1 -> S_SCAN, ptr<=ROWS-1, pass counter<=0.
  - A write in the same cycle as clear_start is applied and is visible to the scan.
- S_SCAN (busy=1), one row examined per cycle:
  - Row ptr all-ones -> S_SHIFT, k<=ptr, pass counter +1 (saturate 7).
  - Row not full and ptr!=0 -> ptr-1.
  - Row not full and ptr==0 -> S_DONE.
- S_SHIFT (busy=1), one copy per cycle:
  - row[k]<=row[k-1], k-1.
  - When k==1: additionally row[0]<=0, then -> S_SCAN with ptr unchanged, so the shifted-in row is rechecked.
  - If ptr==0 on entry (row 0 full): row[0]<=0 in one cycle, then -> S_SCAN at ptr 0.
- S_DONE (busy=1, done=1), one cycle:
  - lines_cleared<=pass counter.
  - lines_total<=lines_total+pass counter, saturating at 255.
  - Then -> S_IDLE.
- clear_start outside S_IDLE is ignored (no queueing).
- Timing, clear_start sampled at edge 0:
  - No full rows: busy high for cycles 1..21, done at cycle 21.
  - Each full row adds 1 + ptr cycles of shift.
- lines_cleared holds its value until the next S_DONE.
- Reset mid-pass: synchronous return to S_IDLE, board cleared, counters 0, no done pulse.

Optional Feature:
Macro BOARD_TOPOUT_EN.
- Defined:
  - Adds output top_out (1 bit).
  - In S_DONE, top_out<=1 if any cell of row 0 or row 1 is occupied after the pass, else 0.
  - top_out holds until the next S_DONE or reset (reset value 0).
  - Game logic uses it as the game-over condition.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset, then sweep all 200 cells on board_rx/ry -> board_rdata=0 everywhere; (rx=10, ry=0) -> 1; (rx=0, ry=20) -> 1; vga_ry=25 -> vga_row=0.
- Write 10 cells of row 19, plus (3,18) set, then pulse clear_start -> after done: row 19=0000001000 (only bit 3), row 18=0; lines_cleared=1, lines_total=1; done exactly once.
- Fill rows 16..19 fully, set (0,15), then clear -> done; every row empty except (0,19)=1; lines_cleared=4, lines_total=5 (cumulative with prior test).
- Empty board, clear_start at edge 0 -> busy high cycles 1..21, done=1 only in cycle 21, lines_cleared=0.
- During busy: issue board_we at (5,5) and a second clear_start -> cell (5,5) stays 0, only one done pulse.
- Assert reset mid-S_SHIFT -> next cycle busy=0, all cells 0, lines_total=0. With BOARD_TOPOUT_EN: set (4,1), clear -> top_out=1; reset -> top_out=0.

Source files
------------

// File: rtl/board_line_clear_if.sv
// Game-logic / renderer side bus of the playfield store: cell writes, collision and row reads,
// and the line-clear handshake. The board drives through the slave modport.
interface board_line_clear_if #(
    parameter int COLS = 10
);
    logic            board_we;
    logic [3:0]      board_wx;
    logic [4:0]      board_wy;
    logic            board_wdata;
    logic [3:0]      board_rx;
    logic [4:0]      board_ry;
    logic            board_rdata;
    logic [4:0]      vga_ry;
    logic [COLS-1:0] vga_row;
    logic            clear_start;
    logic            busy;
    logic            done;
    logic [2:0]      lines_cleared;
    logic [7:0]      lines_total;

    modport master (
        output board_we, board_wx, board_wy, board_wdata, board_rx, board_ry, vga_ry, clear_start,
        input  board_rdata, vga_row, busy, done, lines_cleared, lines_total
    );

    modport slave (
        input  board_we, board_wx, board_wy, board_wdata, board_rx, board_ry, vga_ry, clear_start,
        output board_rdata, vga_row, busy, done, lines_cleared, lines_total
    );
endinterface

// File: rtl/board_line_clear.sv
// Playfield occupancy store with bottom-up full-row removal pass.
// Optional game-over flag top_out is built when BOARD_TOPOUT_EN is defined.
module board_line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic CLOCK_50,
    input  logic reset,
`ifdef BOARD_TOPOUT_EN
    output logic top_out,
`endif
    board_line_clear_if.slave bus
);
    localparam int YW = $clog2(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t          state, state_n;
    logic [COLS-1:0] rows [ROWS];
    logic [YW-1:0]   ptr;
    logic [YW-1:0]   k;
    logic [YW-1:0]   k_m1;
    logic [2:0]      cnt;
    logic            row_full;
    logic            wr_ok;
    logic [8:0]      total_sum;

    assign row_full  = &rows[ptr];
    assign k_m1      = k - YW'(1);
    assign wr_ok     = (32'(bus.board_wx) < COLS) && (32'(bus.board_wy) < ROWS);
    assign total_sum = {1'b0, bus.lines_total} + 9'(cnt);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.clear_start) state_n = S_SCAN;
            S_SCAN: begin
                if (row_full)          state_n = S_SHIFT;
                else if (ptr == '0)    state_n = S_DONE;
            end
            // k==0 only when row 0 itself was full: a single clearing cycle
            S_SHIFT: if (k <= YW'(1)) state_n = S_SCAN;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != S_IDLE);
        bus.done = (state == S_DONE);
    end

    always_comb begin
        bus.board_rdata = 1'b1;
        if ((32'(bus.board_rx) < COLS) && (32'(bus.board_ry) < ROWS))
            bus.board_rdata = rows[bus.board_ry][bus.board_rx];
    end

    always_comb begin
        bus.vga_row = '0;
        if (32'(bus.vga_ry) < ROWS)
            bus.vga_row = rows[bus.vga_ry];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state             <= S_IDLE;
            ptr               <= '0;
            k                 <= '0;
            cnt               <= '0;
            bus.lines_cleared <= '0;
            bus.lines_total   <= '0;
`ifdef BOARD_TOPOUT_EN
            top_out           <= 1'b0;
`endif
            for (int unsigned i = 0; i < ROWS; i++) rows[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (bus.board_we && wr_ok)
                        rows[bus.board_wy][bus.board_wx] <= bus.board_wdata;
                    if (bus.clear_start) begin
                        ptr <= YW'(ROWS - 1);
                        cnt <= '0;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        k <= ptr;
                        if (cnt != 3'd7) cnt <= cnt + 3'd1;
                    end else if (ptr != '0) begin
                        ptr <= ptr - YW'(1);
                    end
                end
                S_SHIFT: begin
                    if (k == '0) begin
                        rows[0] <= '0;
                    end else begin
                        rows[k] <= rows[k_m1];
                        if (k == YW'(1)) rows[0] <= '0;
                        k <= k_m1;
                    end
                end
                S_DONE: begin
                    bus.lines_cleared <= cnt;
                    bus.lines_total   <= total_sum[8] ? 8'hFF : total_sum[7:0];
`ifdef BOARD_TOPOUT_EN
                    top_out           <= (|rows[0]) | (|rows[1]);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_line_clear.sv
// Self-checking bench for board_line_clear: directed sequences, a read-port vector table,
// and randomized boards checked against a row-compaction reference model.
module tb_board_line_clear;
    logic CLOCK_50;
    logic reset;
`ifdef BOARD_TOPOUT_EN
    logic top_out;
`endif

    board_line_clear_if #(.COLS(10)) bus ();

    board_line_clear #(.COLS(10), .ROWS(20)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
`ifdef BOARD_TOPOUT_EN
        .top_out  (top_out),
`endif
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] mdl [20];
    int m_total;

    typedef struct {
        int rx;
        int ry;
        int vy;
        int exp_rd;
        int exp_row;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset;
        for (int y = 0; y < 20; y++) mdl[y] = '0;
        m_total = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_cell(input int x, input int y, input logic d);
        bus.board_we    = 1'b1;
        bus.board_wx    = 4'(x);
        bus.board_wy    = 5'(y);
        bus.board_wdata = d;
        tick();
        bus.board_we    = 1'b0;
        if (x < 10 && y < 20) mdl[y][x] = d;
    endtask

    // Reference: keep non-full rows in bottom-up order, drop full ones, pad empty rows at top.
    function automatic int model_clear();
        logic [9:0] tmp [20];
        int n = 0;
        int dst = 19;
        for (int y = 0; y < 20; y++) tmp[y] = '0;
        for (int y = 19; y >= 0; y--) begin
            if (mdl[y] == 10'h3FF) n++;
            else begin
                tmp[dst] = mdl[y];
                dst--;
            end
        end
        for (int y = 0; y < 20; y++) mdl[y] = tmp[y];
        return n;
    endfunction

    task automatic run_pass(input string name);
        int ndone = 0;
        bit finished = 0;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.done) ndone++;
            if (!bus.busy) begin
                finished = 1;
                break;
            end
            tick();
        end
        check({name, "_finished"}, int'(finished), 1);
        check({name, "_done_count"}, ndone, 1);
    endtask

    task automatic check_rows(input string name);
        for (int y = 0; y < 20; y++) begin
            bus.vga_ry = 5'(y);
            #1;
            check($sformatf("%s_row%0d", name, y), int'(bus.vga_row), int'(mdl[y]));
        end
    endtask

    initial begin
        int n;
        int errs;
        int busy_seen;
        int ndone;
        reset = 1'b1;
        bus.board_we = 0; bus.board_wx = 0; bus.board_wy = 0; bus.board_wdata = 0;
        bus.board_rx = 0; bus.board_ry = 0; bus.vga_ry = 0; bus.clear_start = 0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_lines_cleared", int'(bus.lines_cleared), 0);
        check("rst_lines_total", int'(bus.lines_total), 0);
        errs = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                bus.board_rx = 4'(x);
                bus.board_ry = 5'(y);
                #1;
                if (bus.board_rdata !== 1'b0) errs++;
            end
        check("rst_sweep_nonzero_cells", errs, 0);
        bus.board_rx = 4'd10; bus.board_ry = 5'd0; #1;
        check("wall_rx10", int'(bus.board_rdata), 1);
        bus.board_rx = 4'd0; bus.board_ry = 5'd20; #1;
        check("wall_ry20", int'(bus.board_rdata), 1);
        bus.vga_ry = 5'd25; #1;
        check("vga_oob", int'(bus.vga_row), 0);
        tick();

        // Single full row at the bottom
        for (int x = 0; x < 10; x++) write_cell(x, 19, 1'b1);
        write_cell(3, 18, 1'b1);
        run_pass("t2");
        n = model_clear();
        bus.vga_ry = 5'd19; #1;
        check("t2_row19", int'(bus.vga_row), 10'h008);
        bus.vga_ry = 5'd18; #1;
        check("t2_row18", int'(bus.vga_row), 0);
        check("t2_lines_cleared", int'(bus.lines_cleared), 1);
        check("t2_lines_total", int'(bus.lines_total), 1);
        m_total = 1;

        // Read-port vectors against the known board (only (3,19) set)
        tbl[0] = '{rx: 3,  ry: 19, vy: 19, exp_rd: 1, exp_row: 10'h008};
        tbl[1] = '{rx: 2,  ry: 19, vy: 18, exp_rd: 0, exp_row: 0};
        tbl[2] = '{rx: 10, ry: 0,  vy: 25, exp_rd: 1, exp_row: 0};
        tbl[3] = '{rx: 0,  ry: 20, vy: 20, exp_rd: 1, exp_row: 0};
        tbl[4] = '{rx: 15, ry: 31, vy: 31, exp_rd: 1, exp_row: 0};
        tbl[5] = '{rx: 9,  ry: 19, vy: 0,  exp_rd: 0, exp_row: 0};
        tbl[6] = '{rx: 3,  ry: 18, vy: 19, exp_rd: 0, exp_row: 10'h008};
        tbl[7] = '{rx: 9,  ry: 20, vy: 19, exp_rd: 1, exp_row: 10'h008};
        tbl[8] = '{rx: 0,  ry: 0,  vy: 1,  exp_rd: 0, exp_row: 0};
        tbl[9] = '{rx: 11, ry: 5,  vy: 21, exp_rd: 1, exp_row: 0};
        for (int i = 0; i < 10; i++) begin
            bus.board_rx = 4'(tbl[i].rx);
            bus.board_ry = 5'(tbl[i].ry);
            bus.vga_ry   = 5'(tbl[i].vy);
            #1;
            check($sformatf("tbl%0d_rdata", i), int'(bus.board_rdata), tbl[i].exp_rd);
            check($sformatf("tbl%0d_vga", i), int'(bus.vga_row), tbl[i].exp_row);
        end
        tick();

        // Four full rows plus one stray cell
        for (int y = 16; y < 20; y++)
            for (int x = 0; x < 10; x++) write_cell(x, y, 1'b1);
        write_cell(0, 15, 1'b1);
        run_pass("t3");
        n = model_clear();
        bus.vga_ry = 5'd19; #1;
        check("t3_row19", int'(bus.vga_row), 10'h001);
        check_rows("t3");
        check("t3_lines_cleared", int'(bus.lines_cleared), 4);
        check("t3_lines_total", int'(bus.lines_total), 5);
        m_total = 5;

        // Empty board timing: clear_start sampled at edge 0
        write_cell(0, 19, 1'b0);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        errs = 0;
        for (int c = 1; c <= 25; c++) begin
            if (int'(bus.busy) != int'(c <= 21)) begin
                errs++;
                $display("FAIL t4_busy_cycle%0d: got %0d", c, bus.busy);
            end
            if (int'(bus.done) != int'(c == 21)) begin
                errs++;
                $display("FAIL t4_done_cycle%0d: got %0d", c, bus.done);
            end
            tick();
        end
        check("t4_timing_errors", errs, 0);
        check("t4_lines_cleared", int'(bus.lines_cleared), 0);
        check("t4_lines_total", int'(bus.lines_total), 5);

        // Write and second clear_start during busy are ignored
        bus.clear_start = 1'b1;
        tick();
        bus.board_we = 1'b1; bus.board_wx = 4'd5; bus.board_wy = 5'd5; bus.board_wdata = 1'b1;
        tick();
        bus.board_we = 1'b0;
        bus.clear_start = 1'b0;
        ndone = 0;
        busy_seen = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.done) ndone++;
            if (bus.busy) busy_seen++;
            tick();
        end
        check("t5_done_count", ndone, 1);
        check("t5_busy_cycles", busy_seen, 20);
        bus.board_rx = 4'd5; bus.board_ry = 5'd5; #1;
        check("t5_cell55", int'(bus.board_rdata), 0);
        tick();

        // Reset in the middle of a shift
        for (int x = 0; x < 10; x++) write_cell(x, 19, 1'b1);
        write_cell(2, 10, 1'b1);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        tick();
        tick();
        check("t6_busy_before_reset", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("t6_busy", int'(bus.busy), 0);
        check("t6_done", int'(bus.done), 0);
        check("t6_lines_total", int'(bus.lines_total), 0);
        check("t6_lines_cleared", int'(bus.lines_cleared), 0);
        check_rows("t6");
        tick();

`ifdef BOARD_TOPOUT_EN
        check("top_rst", int'(top_out), 0);
        write_cell(4, 1, 1'b1);
        run_pass("top");
        n = model_clear();
        check("top_set", int'(top_out), 1);
        do_reset();
        check("top_after_reset", int'(top_out), 0);
        tick();
`endif

        // Randomized boards against the compaction model
        for (int it = 0; it < 30; it++) begin
            for (int y = 0; y < 20; y++) begin
                bit full = ($urandom_range(0, 99) < 40);
                for (int x = 0; x < 10; x++)
                    write_cell(x, y, full ? 1'b1 : 1'($urandom_range(0, 1)));
            end
            write_cell(10 + $urandom_range(0, 5), $urandom_range(0, 19), 1'b1);
            write_cell($urandom_range(0, 9), 20 + $urandom_range(0, 11), 1'b1);
            begin
                int rx = $urandom_range(0, 9);
                int ry = $urandom_range(0, 19);
                bus.board_rx = 4'(rx); bus.board_ry = 5'(ry); #1;
                check($sformatf("rnd%0d_rdata", it), int'(bus.board_rdata), int'(mdl[ry][rx]));
                tick();
            end
            run_pass($sformatf("rnd%0d", it));
            n = model_clear();
            m_total = m_total + ((n > 7) ? 7 : n);
            if (m_total > 255) m_total = 255;
            check_rows($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_lines_cleared", it), int'(bus.lines_cleared), (n > 7) ? 7 : n);
            check($sformatf("rnd%0d_lines_total", it), int'(bus.lines_total), m_total);
`ifdef BOARD_TOPOUT_EN
            check($sformatf("rnd%0d_top_out", it), int'(top_out), int'((|mdl[0]) | (|mdl[1])));
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
